// File: rtl/md_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
package md_pkg;

    // E_md_control encodings; 5-7 are reserved and behave as MD_NONE.
    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MFHI = 3'd1;
    localparam logic [2:0] MD_MFLO = 3'd2;
    localparam logic [2:0] MD_MTHI = 3'd3;
    localparam logic [2:0] MD_MTLO = 3'd4;

    // Default latencies, start edge to HI/LO commit edge.
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // Two's-complement negate, used for magnitude/sign fix-up around the divider.
    function automatic logic [31:0] md_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing a 64-bit {hi,lo} result.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        is_signed_i,
    input  logic        is_div_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;

    // Product via extended operands; divide on magnitudes, then restore signs so the
    // quotient truncates toward zero and the remainder follows the dividend.
    always_comb begin
        a_ext   = is_signed_i ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
        b_ext   = is_signed_i ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
        prod    = a_ext * b_ext;

        a_neg   = is_signed_i & a_i[31];
        b_neg   = is_signed_i & b_i[31];
        a_mag   = a_neg ? md_neg(a_i) : a_i;
        b_mag   = b_neg ? md_neg(b_i) : b_i;
        quo_mag = 32'd0;
        rem_mag = 32'd0;
        if (b_mag != 32'd0) begin
            quo_mag = a_mag / b_mag;
            rem_mag = a_mag % b_mag;
        end
        quo     = (a_neg ^ b_neg) ? md_neg(quo_mag) : quo_mag;
        rem     = a_neg ? md_neg(rem_mag) : rem_mag;

        result_o   = is_div_i ? {rem, quo} : prod;
        div_zero_o = is_div_i & (b_i == 32'd0);
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        E_start_mult,
    input  logic        E_start_div,
    input  logic        E_md_signal,
    input  logic [2:0]  E_md_control,
    input  logic        E_updatemd,
    input  logic [31:0] E_Qa,
    input  logic [31:0] E_Qb,
    output logic [3:0]  busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out,
    output logic        md_done
);

    localparam logic [3:0] MultLatW = 4'(MULT_LAT);
    localparam logic [3:0] DivLatW  = 4'(DIV_LAT);

    logic [3:0]  busy_d, busy_q;
    logic [31:0] ph_d, ph_q, pl_d, pl_q;
    logic [31:0] hi_d, hi_q, lo_d, lo_q;
    logic        dz_d, dz_q;
    logic        done_d, done_q;

    logic [63:0] arith_res;
    logic        arith_dz;

    // Mult wins when both starts are present, so the datapath only divides without start_mult.
    md_arith u_arith (
        .a_i         (E_Qa),
        .b_i         (E_Qb),
        .is_signed_i (E_md_signal),
        .is_div_i    (~E_start_mult),
        .result_o    (arith_res),
        .div_zero_o  (arith_dz)
    );

    // Next state: MT writes and starts only when idle; otherwise count down and commit on 1->0.
    always_comb begin
        busy_d = busy_q;
        ph_d   = ph_q;
        pl_d   = pl_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        if (busy_q == 4'd0) begin
            if (E_updatemd && E_md_control == MD_MTHI) hi_d = E_Qa;
            if (E_updatemd && E_md_control == MD_MTLO) lo_d = E_Qa;
            if (E_start_mult) begin
                {ph_d, pl_d} = arith_res;
                dz_d         = 1'b0;
                busy_d       = MultLatW;
            end else if (E_start_div) begin
                {ph_d, pl_d} = arith_res;
                dz_d         = arith_dz;
                busy_d       = DivLatW;
            end
        end else begin
            busy_d = busy_q - 4'd1;
            if (busy_q == 4'd1) begin
                done_d = 1'b1;
                // Divide by zero leaves HI/LO untouched but still signals completion.
                if (!dz_q) begin
                    hi_d = ph_q;
                    lo_d = pl_q;
                end
            end
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            busy_q <= 4'd0;
            ph_q   <= 32'd0;
            pl_q   <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ph_q   <= ph_d;
            pl_q   <= pl_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    // MF read mux; reserved and MT encodings read as zero.
    always_comb begin
        case (E_md_control)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

    assign busy    = busy_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign md_done = done_q;

    // Upstream must stall starts and MT writes while an operation is in flight.
    always @(posedge Clk) begin
        if (Reset && busy_q != 4'd0) begin
            assert (!(E_start_mult || E_start_div))
                else $warning("ex_muldiv_unit: start ignored while busy");
            assert (!(E_updatemd && (E_md_control == MD_MTHI || E_md_control == MD_MTLO)))
                else $warning("ex_muldiv_unit: MT write ignored while busy");
        end
    end

endmodule
